// File: rtl/uart_tx_fifo.sv
// 16-deep byte FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       tx,
  output logic       tx_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              full_reg, empty_reg;
  state_t            state_reg, state_next;
  logic [15:0]       baud_reg, baud_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        sh_reg;
  logic              tx_reg, tx_next;
  logic              push, pop, shift, baud_done;
`ifdef UART_TX_PARITY_EN
  logic              par_reg;
`endif

  // A write while full is dropped regardless of a same-cycle pop.
  assign push      = wr_en & ~full_reg;
  assign baud_done = (baud_reg == 16'(CLKS_PER_BIT - 1));

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage and shift register carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= wr_data;
    if (pop) begin
      sh_reg <= mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
      par_reg <= ^mem[rd_ptr_reg];
`endif
    end else if (shift) begin
      sh_reg <= sh_reg >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      tx_reg     <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == (ADDR_W+1)'(DEPTH));
      empty_reg <= (count_next == '0);
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
    end
  end

  // tx_next is the line level for the state being entered, keeping tx registered.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg + 16'd1;
    bit_next   = bit_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    shift      = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        if (!empty_reg) begin
          pop        = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_done) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = sh_reg[0];
        end
      end
      DATA: begin
        tx_next = sh_reg[0];
        if (baud_done) begin
          baud_next = '0;
          shift     = 1'b1;
          bit_next  = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = par_reg;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            tx_next = sh_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = par_reg;
        if (baud_done) begin
          state_next = STOP;
          baud_next  = '0;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (baud_done) begin
          state_next = IDLE;
          baud_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at CLKS_PER_BIT=4; a line monitor decodes
// frames and checks them against bytes queued when writes were driven.
module tb_uart_tx_fifo;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, tx, tx_busy;

  int  vectors = 0;
  int  miscompares = 0;
  logic [7:0] exp_q[$];
  bit  mon_en = 1'b1;
  bit  b2b_chk = 1'b0;
  longint prev_stop = -1;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .ADDR_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Line monitor: detect start bit, sample each bit mid-cell, compare with scoreboard.
  initial begin
    logic [7:0] d, e;
    logic       sb, stp, par;
    longint     s;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n && tx === 1'b0) begin
        s = $time / 10;
        if (b2b_chk && prev_stop >= 0) begin
          vectors++;
          if (s - prev_stop != C + 1) begin
            miscompares++;
            $display("FAIL gap: actual %0d tx=1 cycles, required %0d", s - prev_stop, C + 1);
          end
        end
        repeat (2) @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          d[i] = tx;
        end
        par = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (C) @(negedge clk);
        par = tx;
`endif
        repeat (C) @(negedge clk);
        stp = tx;
        prev_stop = s + (NBITS - 1) * C;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL frame: actual unexpected byte %02h, required no frame", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e || sb !== 1'b0 || stp !== 1'b1
`ifdef UART_TX_PARITY_EN
              || par !== ^e
`endif
             ) begin
            miscompares++;
            $display("FAIL frame: actual byte %02h start %b stop %b par %b, required byte %02h start 0 stop 1",
                     d, sb, stp, par, e);
          end else begin
            $display("frame ok: byte %02h", d);
          end
        end
      end
    end
  end

  // Caller sits just after a rising edge; returns just after the next one.
  task automatic write_byte(input logic [7:0] b, input bit expect_tx);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_tx) exp_q.push_back(b);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && tx_busy === 1'b0 && empty === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain: actual %0d bytes outstanding after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: actual tx=%b busy=%b empty=%b full=%b, required 1 0 1 0", tx, tx_busy, empty, full);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [9:0] pat = 10'b1010000010;  // bit k = frame cell k of 0x41
    prev_stop = -1;
    b2b_chk   = 1'b0;
    @(posedge clk); #1;
    write_byte(8'h41, 1'b1);
    @(negedge clk);
    vectors++;
    if (empty !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL single_n1: actual empty=%b tx=%b, required 0 1", empty, tx);
    end
    @(negedge clk);
    vectors++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_fall: actual tx=%b busy=%b, required 0 1", tx, tx_busy);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
`ifdef UART_TX_PARITY_EN
      if (k == 9) repeat (C) @(negedge clk);
`endif
      vectors++;
      if (tx !== pat[k]) begin
        miscompares++;
        $display("FAIL single_bit%0d: actual %b, required %b", k, tx, pat[k]);
      end
      if (k < 9) repeat (C) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (tx_busy !== 1'b0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL single_done: actual busy=%b empty=%b, required 0 1", tx_busy, empty);
    end
    wait_drain(50);
  endtask

  task automatic test_back_to_back();
    string msg = "HELLO WORLD!!!!!";
    prev_stop = -1;
    b2b_chk   = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) write_byte(msg[i], 1'b1);
    @(negedge clk);
    vectors++;
    if (full !== 1'b0 || empty !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_level: actual full=%b empty=%b, required 0 0 (15 queued)", full, empty);
    end
    wait_drain(16 * (NBITS * C + 1) + 100);
    b2b_chk = 1'b0;
  endtask

  task automatic test_overflow();
    prev_stop = -1;
    b2b_chk   = 1'b1;
    @(posedge clk); #1;
    write_byte(8'hA5, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i), 1'b1);
    @(negedge clk);
    vectors++;
    if (full !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_full: actual full=%b, required 1", full);
    end
    @(posedge clk); #1;
    write_byte(8'hFF, 1'b0);
    @(negedge clk);
    vectors++;
    if (full !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_drop: actual full=%b, required 1", full);
    end
    wait_drain(17 * (NBITS * C + 1) + 100);
    b2b_chk = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    int bad = 0;
    mon_en = 1'b0;
    @(posedge clk); #1;
    write_byte(8'h55, 1'b0);
    write_byte(8'h12, 1'b0);
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL rst_start: actual no start bit in 20 cycles, required start bit");
    end
    repeat (C + 3 * C + 1) @(negedge clk);  // inside DATA bit 3
    reset_n = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1 || empty !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_abort: actual tx=%b empty=%b busy=%b, required 1 1 0", tx, empty, tx_busy);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || empty !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rst_residual: actual %0d active cycles after release, required 0", bad);
    end
    mon_en = 1'b1;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] b, input logic p);
    int busy_cycles = 0;
    int n = 0;
    prev_stop = -1;
    @(posedge clk); #1;
    write_byte(b, 1'b1);
    while (tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 60; i++) begin
      if (tx_busy === 1'b1) busy_cycles++;
      if (i == 2 + 9 * C) begin
        vectors++;
        if (tx !== p) begin
          miscompares++;
          $display("FAIL parity_%02h: actual %b, required %b", b, tx, p);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (busy_cycles != 11 * C) begin
      miscompares++;
      $display("FAIL parity_len_%02h: actual %0d cycles, required %0d", b, busy_cycles, 11 * C);
    end
    wait_drain(50);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: actual %0d bytes never sent, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
